game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Parametrised top-level game sequencer for the VGA rhythm game, successor to the single-shot control FSM. It walks a configurable number of draw layers with per-layer done handshakes, runs the note animation, and tracks lives, notes-per-level and level progression. It ends in a game-over or win screen, and can optionally recover from stalled draw engines with a watchdog. It sits between the datapath draw engines and the board LEDs/keys.

## Interface
- NUM_LAYERS, 3: draw layers per frame (1–8); layer 0 = background, drawn first.
- LIVES, 3: starting lives (1–7).
- LEVELS, 4: levels to clear for a win (1–15).
- NOTES_PER_LEVEL, 8: note hits needed to advance a level (1–255).
- TIMEOUT_W, 20: watchdog counter width.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start; also returns from OVER/WIN to IDLE.
- pause  in  1  level-sensitive pause request.
- layer_done  in  NUM_LAYERS  per-layer draw-complete pulse/level.
- hit_done  in  1  current note hit, animation finished.
- miss  in  1  current note missed.
- cleared  in  1  black-fill engine finished.
- ld_layer  out  NUM_LAYERS  one-hot draw enable for the active layer.
- ld_line, ld_coord, ld_plot, ld_black  out  1 each  datapath loads.
- ld_gameover, ld_win  out  1 each  end-screen enables.
- lives  out  3  remaining lives.
- level  out  4  current level, 0-based.
- timeout_err  out  1  sticky watchdog flag.
- LED  out  10  status LEDs.

## Operation
- Moore FSM. Encoding: IDLE=0, DRAW=1, LINE=2, GEN=3, ANIM=4, PAUSED=5, CLEAR=6, OVER=7, WIN=8. Outputs decode combinationally from registered state and counters.
- IDLE: all ld_* low. go=1 → DRAW with layer_idx=0, note_cnt=0.
- DRAW: ld_layer[layer_idx]=1.
  - layer_done[layer_idx]=1 → layer_idx+1 and stay in DRAW.
  - If layer_idx=NUM_LAYERS-1 → LINE, layer_idx=0.
  - layer_done bits of other layers are ignored.
- LINE: ld_line=1 for one cycle → GEN.
- GEN: ld_coord=1 for one cycle → ANIM.
- ANIM: ld_plot=1. Priority is hit_done > miss > pause.
  - hit_done, note_cnt<NOTES_PER_LEVEL-1: note_cnt+1 → DRAW.
  - hit_done, note_cnt=NOTES_PER_LEVEL-1: note_cnt←0.
    - level<LEVELS-1: level+1 → DRAW.
    - Otherwise: win_flag←1 → CLEAR.
  - miss, lives>1: lives-1 → DRAW.
  - miss, lives=1: lives←0, win_flag←0 → CLEAR.
  - pause → PAUSED.
- PAUSED: no ld_* asserted. hit_done and miss are ignored. pause=0 → ANIM.
- CLEAR: ld_black=1. cleared → WIN if win_flag, else OVER.
- OVER: ld_gameover=1. WIN: ld_win=1. Both hold until go=1 → IDLE with lives=LIVES, level=0, note_cnt=0, win_flag=0. timeout_err is not cleared by go.
- go is ignored in every state except IDLE, OVER and WIN.
- LED mapping:
  - LED[3:0] = state code.
  - LED[6:4] = lives.
  - LED[8:7] = level[1:0].
  - LED[9] = 1 constant.

## Timing
- Reset values: state=IDLE, layer_idx=0, note_cnt=0, lives=LIVES, level=0, win_flag=0, timeout_err=0, watchdog=0.
- Output values in reset: all ld_* = 0, LED=10'b1_00_LIVES_0000.
- reset dominates all inputs in any state, including mid-DRAW or mid-ANIM. The next edge gives IDLE.
- Each transition takes effect on the clk edge that samples the condition. Outputs change in that same cycle after the edge.
- Fixed latencies:
  - go in IDLE → ld_layer[0] high 1 cycle later.
  - Last layer_done → ld_line 1 cycle later.
  - Last layer_done → ld_plot 3 cycles later.
- layer_done held high for multiple cycles advances one layer per cycle. Draw engines must deassert done when their ld_layer bit drops.
- Counters never wrap: lives saturates at 0, level at LEVELS-1, note_cnt resets only via hit-level rollover or reset/go.

## Configuration
- GAME_FLOW_WATCHDOG_EN defined:
  - A TIMEOUT_W-bit counter clears on every state change and increments while in DRAW or CLEAR.
  - When it reaches all-ones, timeout_err←1 (sticky until reset) and the FSM advances as if the awaited done/cleared had arrived.
- GAME_FLOW_WATCHDOG_EN undefined: no counter is built, timeout_err is tied 0, and DRAW/CLEAR wait indefinitely.

## Test plan
- Reset then go=1, layer_done pulsed 0,1,2 → ld_layer 001,010,100 in turn, then ld_line 1 cycle, ld_coord 1 cycle, ld_plot high; LED[3:0]=4.
- NOTES_PER_LEVEL=2, LEVELS=2: four hit_done in ANIM, each followed by a full redraw → level 0→1, then CLEAR. cleared → WIN, ld_win=1.
- Three misses from LIVES=3 → lives 2,1,0. The third miss gives CLEAR, then OVER on cleared; go → IDLE with lives=3.
- hit_done and miss asserted in the same ANIM cycle → note_cnt+1, lives unchanged. pause=1 in ANIM → PAUSED; a hit_done there is ignored; pause=0 → ANIM.
- reset asserted mid-DRAW with layer_idx=1 and lives=1 → next cycle IDLE, lives=3, ld_layer=0.
- With GAME_FLOW_WATCHDOG_EN and TIMEOUT_W=4, layer_done held 0 → after 15 cycles in DRAW the layer advances and timeout_err=1; timeout_err stays 1 after a later go.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: layered frame draw, note animation, lives/level tracking, end screens.
// Optional stall watchdog on DRAW/CLEAR is built when GAME_FLOW_WATCHDOG_EN is defined.
module game_flow_ctrl #(
    parameter int NUM_LAYERS      = 3,
    parameter int LIVES           = 3,
    parameter int LEVELS          = 4,
    parameter int NOTES_PER_LEVEL = 8,
    parameter int TIMEOUT_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  pause,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic                  hit_done,
    input  logic                  miss,
    input  logic                  cleared,
    output logic [NUM_LAYERS-1:0] ld_layer,
    output logic                  ld_line,
    output logic                  ld_coord,
    output logic                  ld_plot,
    output logic                  ld_black,
    output logic                  ld_gameover,
    output logic                  ld_win,
    output logic [2:0]            lives,
    output logic [3:0]            level,
    output logic                  timeout_err,
    output logic [9:0]            LED
);

    localparam int                LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [7:0]        NOTE_LAST  = 8'(NOTES_PER_LEVEL - 1);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]        LEVEL_LAST = 4'(LEVELS - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DRAW   = 4'd1,
        LINE   = 4'd2,
        GEN    = 4'd3,
        ANIM   = 4'd4,
        PAUSED = 4'd5,
        CLEAR  = 4'd6,
        OVER   = 4'd7,
        WIN    = 4'd8
    } state_t;

    state_t            state, state_nx;
    logic [LIDX_W-1:0] layer_idx, layer_nx;
    logic [7:0]        note_cnt, note_nx;
    logic [2:0]        lives_nx;
    logic [3:0]        level_nx;
    logic              win_flag, win_nx;
    logic              wd_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            layer_idx <= '0;
            note_cnt  <= '0;
            lives     <= LIVES_INIT;
            level     <= '0;
            win_flag  <= 1'b0;
        end else begin
            state     <= state_nx;
            layer_idx <= layer_nx;
            note_cnt  <= note_nx;
            lives     <= lives_nx;
            level     <= level_nx;
            win_flag  <= win_nx;
        end
    end

    always_comb begin
        state_nx = state;
        layer_nx = layer_idx;
        note_nx  = note_cnt;
        lives_nx = lives;
        level_nx = level;
        win_nx   = win_flag;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nx = DRAW;
                    layer_nx = '0;
                    note_nx  = '0;
                end
            end
            DRAW: begin
                // Only the active layer's done counts; other engines' flags are ignored.
                if (layer_done[layer_idx] || wd_fire) begin
                    if (layer_idx == LAYER_LAST) begin
                        state_nx = LINE;
                        layer_nx = '0;
                    end else begin
                        layer_nx = layer_idx + 1'b1;
                    end
                end
            end
            LINE: state_nx = GEN;
            GEN:  state_nx = ANIM;
            ANIM: begin
                if (hit_done) begin
                    if (note_cnt != NOTE_LAST) begin
                        note_nx  = note_cnt + 1'b1;
                        state_nx = DRAW;
                    end else begin
                        note_nx = '0;
                        if (level != LEVEL_LAST) begin
                            level_nx = level + 1'b1;
                            state_nx = DRAW;
                        end else begin
                            win_nx   = 1'b1;
                            state_nx = CLEAR;
                        end
                    end
                end else if (miss) begin
                    if (lives > 3'd1) begin
                        lives_nx = lives - 1'b1;
                        state_nx = DRAW;
                    end else begin
                        lives_nx = '0;
                        win_nx   = 1'b0;
                        state_nx = CLEAR;
                    end
                end else if (pause) begin
                    state_nx = PAUSED;
                end
            end
            PAUSED: begin
                if (!pause) state_nx = ANIM;
            end
            CLEAR: begin
                if (cleared || wd_fire) state_nx = win_flag ? WIN : OVER;
            end
            OVER, WIN: begin
                if (go) begin
                    state_nx = IDLE;
                    lives_nx = LIVES_INIT;
                    level_nx = '0;
                    note_nx  = '0;
                    win_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_layer    = '0;
        ld_line     = 1'b0;
        ld_coord    = 1'b0;
        ld_plot     = 1'b0;
        ld_black    = 1'b0;
        ld_gameover = 1'b0;
        ld_win      = 1'b0;
        case (state)
            DRAW:    ld_layer    = NUM_LAYERS'(1) << layer_idx;
            LINE:    ld_line     = 1'b1;
            GEN:     ld_coord    = 1'b1;
            ANIM:    ld_plot     = 1'b1;
            CLEAR:   ld_black    = 1'b1;
            OVER:    ld_gameover = 1'b1;
            WIN:     ld_win      = 1'b1;
            default: ;
        endcase
    end

    assign LED = {1'b1, level[1:0], lives, 4'(state)};

`ifdef GAME_FLOW_WATCHDOG_EN
    localparam logic [TIMEOUT_W-1:0] WD_ONES = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_ONES - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] wd_cnt;

    // Fires on the edge where the count reaches all-ones; the counter restarts so a
    // following stalled layer gets its own full window.
    assign wd_fire = ((state == DRAW) || (state == CLEAR)) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state_nx != state) || wd_fire)
                wd_cnt <= '0;
            else if ((state == DRAW) || (state == CLEAR))
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: per-cycle expected output vectors are queued with the
// stimulus, observed vectors are queued after each edge, and each scenario task compares them.
module tb_game_flow_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_DRAW = 4'd1, S_LINE = 4'd2, S_GEN = 4'd3,
                           S_ANIM = 4'd4, S_PAUSED = 4'd5, S_CLEAR = 4'd6,
                           S_OVER = 4'd7, S_WIN = 4'd8;

    logic       clk = 1'b0;
    logic       reset, go, pause, hit_done, miss, cleared;
    logic [2:0] layer_done;
    logic [2:0] ld_layer;
    logic       ld_line, ld_coord, ld_plot, ld_black, ld_gameover, ld_win;
    logic [2:0] lives;
    logic [3:0] level;
    logic       timeout_err;
    logic [9:0] LED;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       nm;
        logic [26:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [26:0] obs_q[$];

    game_flow_ctrl #(
        .NUM_LAYERS(3), .LIVES(3), .LEVELS(2), .NOTES_PER_LEVEL(2), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .pause(pause), .layer_done(layer_done),
        .hit_done(hit_done), .miss(miss), .cleared(cleared),
        .ld_layer(ld_layer), .ld_line(ld_line), .ld_coord(ld_coord), .ld_plot(ld_plot),
        .ld_black(ld_black), .ld_gameover(ld_gameover), .ld_win(ld_win),
        .lives(lives), .level(level), .timeout_err(timeout_err), .LED(LED)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // Expected output vector derived from the state table: which load each state drives,
    // plus lives/level/LED packing.
    function automatic logic [26:0] model(input logic [3:0] st, input logic [1:0] li,
                                          input logic [2:0] lv, input logic [3:0] lev,
                                          input logic te);
        logic [2:0] lay;
        lay = (st == S_DRAW) ? (3'b001 << li) : 3'b000;
        return {lay, (st == S_LINE), (st == S_GEN), (st == S_ANIM), (st == S_CLEAR),
                (st == S_OVER), (st == S_WIN), lv, lev, {1'b1, lev[1:0], lv, st}, te};
    endfunction

    task automatic tick(input string nm, input logic rs, input logic g, input logic p,
                        input logic [2:0] ld, input logic h, input logic m, input logic c,
                        input logic [3:0] st, input logic [1:0] li, input logic [2:0] lv,
                        input logic [3:0] lev, input logic te);
        exp_t e;
        reset = rs; go = g; pause = p; layer_done = ld;
        hit_done = h; miss = m; cleared = c;
        e.nm = nm;
        e.v  = model(st, li, lv, lev, te);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back({ld_layer, ld_line, ld_coord, ld_plot, ld_black, ld_gameover, ld_win,
                         lives, level, LED, timeout_err});
    endtask

    // Full redraw from DRAW layer 0 through LINE and GEN back into ANIM.
    task automatic frame(input string nm, input logic [2:0] lv, input logic [3:0] lev,
                         input logic te);
        tick({nm, "_l0"},  0, 0, 0, 3'b001, 0, 0, 0, S_DRAW, 2'd1, lv, lev, te);
        tick({nm, "_l1"},  0, 0, 0, 3'b010, 0, 0, 0, S_DRAW, 2'd2, lv, lev, te);
        tick({nm, "_l2"},  0, 0, 0, 3'b100, 0, 0, 0, S_LINE, 2'd0, lv, lev, te);
        tick({nm, "_gen"}, 0, 0, 0, 3'b000, 0, 0, 0, S_GEN,  2'd0, lv, lev, te);
        tick({nm, "_anm"}, 0, 0, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, lv, lev, te);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [26:0] o;
        tick("reset0", 1, 0, 0, 3'b000, 0, 0, 0, S_IDLE, 0, 3'd3, 4'd0, 0);
        tick("reset1", 1, 1, 1, 3'b111, 1, 1, 1, S_IDLE, 0, 3'd3, 4'd0, 0);
        tick("idle",   0, 0, 0, 3'b111, 1, 1, 1, S_IDLE, 0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_draw_sequence();
        exp_t e;
        logic [26:0] o;
        tick("go",         0, 1, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        tick("other_done", 0, 0, 0, 3'b110, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        tick("done0",      0, 0, 0, 3'b001, 0, 0, 0, S_DRAW, 2'd1, 3'd3, 4'd0, 0);
        tick("stale0",     0, 0, 0, 3'b001, 0, 0, 0, S_DRAW, 2'd1, 3'd3, 4'd0, 0);
        tick("done1",      0, 0, 0, 3'b010, 0, 0, 0, S_DRAW, 2'd2, 3'd3, 4'd0, 0);
        tick("done2",      0, 0, 0, 3'b100, 0, 0, 0, S_LINE, 2'd0, 3'd3, 4'd0, 0);
        tick("line",       0, 0, 0, 3'b000, 0, 0, 0, S_GEN,  2'd0, 3'd3, 4'd0, 0);
        tick("coord",      0, 0, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, 3'd3, 4'd0, 0);
        tick("anim_hold",  0, 0, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, 3'd3, 4'd0, 0);
        tick("go_in_anim", 0, 1, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_priority_and_pause();
        exp_t e;
        logic [26:0] o;
        // Hit and miss together: the hit wins, so the note count reaches 1 and lives stay 3.
        tick("hit_and_miss", 0, 0, 0, 3'b000, 1, 1, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        frame("redraw_a", 3'd3, 4'd0, 0);
        tick("pause",        0, 0, 1, 3'b000, 0, 0, 0, S_PAUSED, 2'd0, 3'd3, 4'd0, 0);
        tick("paused_hit",   0, 0, 1, 3'b000, 1, 0, 0, S_PAUSED, 2'd0, 3'd3, 4'd0, 0);
        tick("paused_miss",  0, 1, 1, 3'b000, 0, 1, 0, S_PAUSED, 2'd0, 3'd3, 4'd0, 0);
        tick("unpause",      0, 0, 0, 3'b000, 0, 0, 0, S_ANIM,   2'd0, 3'd3, 4'd0, 0);
        // Second counted hit rolls the note count and advances the level.
        tick("level_up",     0, 0, 0, 3'b000, 1, 0, 0, S_DRAW,   2'd0, 3'd3, 4'd1, 0);
        frame("redraw_b", 3'd3, 4'd1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_win();
        exp_t e;
        logic [26:0] o;
        tick("hit3",        0, 0, 0, 3'b000, 1, 0, 0, S_DRAW,  2'd0, 3'd3, 4'd1, 0);
        frame("redraw_c", 3'd3, 4'd1, 0);
        tick("hit4_last",   0, 0, 0, 3'b000, 1, 0, 0, S_CLEAR, 2'd0, 3'd3, 4'd1, 0);
        tick("clear_wait",  0, 0, 0, 3'b000, 0, 0, 0, S_CLEAR, 2'd0, 3'd3, 4'd1, 0);
        tick("clear_go",    0, 1, 0, 3'b000, 0, 0, 0, S_CLEAR, 2'd0, 3'd3, 4'd1, 0);
        tick("cleared_win", 0, 0, 0, 3'b000, 0, 0, 1, S_WIN,   2'd0, 3'd3, 4'd1, 0);
        tick("win_hold",    0, 0, 0, 3'b000, 1, 1, 1, S_WIN,   2'd0, 3'd3, 4'd1, 0);
        tick("win_go",      0, 1, 0, 3'b000, 0, 0, 0, S_IDLE,  2'd0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_lives();
        exp_t e;
        logic [26:0] o;
        tick("go",          0, 1, 0, 3'b000, 0, 0, 0, S_DRAW,  2'd0, 3'd3, 4'd0, 0);
        frame("f0", 3'd3, 4'd0, 0);
        tick("miss1",       0, 0, 0, 3'b000, 0, 1, 0, S_DRAW,  2'd0, 3'd2, 4'd0, 0);
        frame("f1", 3'd2, 4'd0, 0);
        tick("miss2",       0, 0, 0, 3'b000, 0, 1, 0, S_DRAW,  2'd0, 3'd1, 4'd0, 0);
        frame("f2", 3'd1, 4'd0, 0);
        tick("miss3",       0, 0, 0, 3'b000, 0, 1, 0, S_CLEAR, 2'd0, 3'd0, 4'd0, 0);
        tick("cleared_ovr", 0, 0, 0, 3'b000, 0, 0, 1, S_OVER,  2'd0, 3'd0, 4'd0, 0);
        tick("over_hold",   0, 0, 0, 3'b000, 0, 1, 0, S_OVER,  2'd0, 3'd0, 4'd0, 0);
        tick("over_go",     0, 1, 0, 3'b000, 0, 0, 0, S_IDLE,  2'd0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        exp_t e;
        logic [26:0] o;
        tick("go",        0, 1, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        frame("g0", 3'd3, 4'd0, 0);
        tick("miss1",     0, 0, 0, 3'b000, 0, 1, 0, S_DRAW, 2'd0, 3'd2, 4'd0, 0);
        frame("g1", 3'd2, 4'd0, 0);
        tick("miss2",     0, 0, 0, 3'b000, 0, 1, 0, S_DRAW, 2'd0, 3'd1, 4'd0, 0);
        tick("done0",     0, 0, 0, 3'b001, 0, 0, 0, S_DRAW, 2'd1, 3'd1, 4'd0, 0);
        tick("rst_draw",  1, 0, 0, 3'b010, 0, 0, 0, S_IDLE, 2'd0, 3'd3, 4'd0, 0);
        tick("post_rst",  0, 0, 0, 3'b000, 0, 0, 0, S_IDLE, 2'd0, 3'd3, 4'd0, 0);
        // Reset during ANIM as well.
        tick("go2",       0, 1, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        frame("g2", 3'd3, 4'd0, 0);
        tick("rst_anim",  1, 0, 0, 3'b000, 1, 0, 0, S_IDLE, 2'd0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [26:0] o;
        tick("go",       0, 1, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        tick("held_a",   0, 0, 0, 3'b111, 0, 0, 0, S_DRAW, 2'd1, 3'd3, 4'd0, 0);
        tick("held_b",   0, 0, 0, 3'b111, 0, 0, 0, S_DRAW, 2'd2, 3'd3, 4'd0, 0);
        tick("held_c",   0, 0, 0, 3'b111, 0, 0, 0, S_LINE, 2'd0, 3'd3, 4'd0, 0);
        tick("gen",      0, 0, 0, 3'b000, 0, 0, 0, S_GEN,  2'd0, 3'd3, 4'd0, 0);
        tick("anim",     0, 0, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, 3'd3, 4'd0, 0);
        tick("hit_dn",   0, 0, 0, 3'b000, 1, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        tick("rst",      1, 0, 0, 3'b000, 0, 0, 0, S_IDLE, 2'd0, 3'd3, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask

`ifdef GAME_FLOW_WATCHDOG_EN
    task automatic test_watchdog();
        exp_t e;
        logic [26:0] o;
        tick("wd_go", 0, 1, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        for (int i = 0; i < 14; i++)
            tick("wd_stall", 0, 0, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd0, 3'd3, 4'd0, 0);
        tick("wd_fire",  0, 0, 0, 3'b000, 0, 0, 0, S_DRAW, 2'd1, 3'd3, 4'd0, 1);
        tick("wd_l1",    0, 0, 0, 3'b010, 0, 0, 0, S_DRAW, 2'd2, 3'd3, 4'd0, 1);
        tick("wd_l2",    0, 0, 0, 3'b100, 0, 0, 0, S_LINE, 2'd0, 3'd3, 4'd0, 1);
        tick("wd_gen",   0, 0, 0, 3'b000, 0, 0, 0, S_GEN,  2'd0, 3'd3, 4'd0, 1);
        tick("wd_anim",  0, 0, 0, 3'b000, 0, 0, 0, S_ANIM, 2'd0, 3'd3, 4'd0, 1);
        tick("wd_m1",    0, 0, 0, 3'b000, 0, 1, 0, S_DRAW, 2'd0, 3'd2, 4'd0, 1);
        frame("wd_f1", 3'd2, 4'd0, 1);
        tick("wd_m2",    0, 0, 0, 3'b000, 0, 1, 0, S_DRAW, 2'd0, 3'd1, 4'd0, 1);
        frame("wd_f2", 3'd1, 4'd0, 1);
        tick("wd_m3",    0, 0, 0, 3'b000, 0, 1, 0, S_CLEAR, 2'd0, 3'd0, 4'd0, 1);
        for (int i = 0; i < 14; i++)
            tick("wd_clr_stall", 0, 0, 0, 3'b000, 0, 0, 0, S_CLEAR, 2'd0, 3'd0, 4'd0, 1);
        tick("wd_clr_fire", 0, 0, 0, 3'b000, 0, 0, 0, S_OVER, 2'd0, 3'd0, 4'd0, 1);
        tick("wd_go_idle",  0, 1, 0, 3'b000, 0, 0, 0, S_IDLE, 2'd0, 3'd3, 4'd0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.nm, o, e.v);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; go = 1'b0; pause = 1'b0; layer_done = 3'b000;
        hit_done = 1'b0; miss = 1'b0; cleared = 1'b0;
        test_reset();
        test_draw_sequence();
        test_priority_and_pause();
        test_win();
        test_lives();
        test_reset_mid_draw();
        test_back_to_back();
`ifdef GAME_FLOW_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
